gpio_checkpoint_monitor: RTL

GPIO_CHECKPOINT_MONITOR -- requirements
Module: gpio_checkpoint_monitor

---
 rtl/gpio_checkpoint_monitor.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_checkpoint_monitor.sv
// GPIO checkpoint monitor.
// Watches a checkpoint/stage field pair driven by firmware over GPIO, logs every
// checkpoint change into a small event FIFO, and reports pass/fail/timeout once
// the firmware signals completion (pass is followed by a fixed drain interval).
module gpio_checkpoint_monitor #(
    parameter int               CHK_W         = 16,
    parameter int               STG_W         = 8,
    parameter int               SEQ_W         = 8,
    parameter logic [CHK_W-1:0] PASS_CODE     = 16'hAB51,
    parameter logic [CHK_W-1:0] FAIL_CODE     = 16'hAB5F,
    parameter logic [CHK_W-1:0] STAGE_CODE    = 16'hAB40,
    parameter int               TIMEOUT_CYC   = 250000,
    parameter int               POST_PASS_CYC = 400,
    parameter int               FIFO_DEPTH    = 16
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           start,
    input  logic [CHK_W-1:0]               chk_i,
    input  logic [STG_W-1:0]               stg_i,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [SEQ_W+STG_W+CHK_W:0]     evt_data,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic                           overflow,
    output logic [SEQ_W-1:0]               evt_count
);

    localparam int EVT_W = 1 + SEQ_W + STG_W + CHK_W;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int DRN_W = $clog2(POST_PASS_CYC + 1);

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(POST_PASS_CYC - 1);
    localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Event word layout: {is_stage, seq, stg, chk}
    function automatic logic [EVT_W-1:0] pack_event(
        input logic             is_stage,
        input logic [SEQ_W-1:0] seq,
        input logic [STG_W-1:0] stg,
        input logic [CHK_W-1:0] chk
    );
        return {is_stage, seq, stg, chk};
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic               r_timeout;
    logic               r_overflow;
    logic [SEQ_W-1:0]   r_evt_count;
    logic [CHK_W-1:0]   r_prev;
    logic [TMO_W-1:0]   r_tcnt;
    logic [DRN_W-1:0]   r_dcnt;

    logic [EVT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_next;
    logic               r_valid;

    logic               w_arm;
    logic               w_evt;
    logic               w_is_pass;
    logic               w_is_fail;
    logic               w_tmo_hit;
    logic               w_drn_end;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [EVT_W-1:0]   w_evt_word;

    assign w_arm      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_evt      = (r_state == S_ARMED) && (chk_i != r_prev);
    assign w_is_pass  = w_evt && (chk_i == PASS_CODE);
    assign w_is_fail  = w_evt && (chk_i == FAIL_CODE);
    assign w_tmo_hit  = (r_state == S_ARMED) && (r_tcnt == TMO_LAST);
    assign w_drn_end  = (r_state == S_DRAIN) && (r_dcnt == DRN_LAST);
    assign w_pop      = r_valid && evt_ready;
    assign w_full     = (r_cnt == FIFO_FULL);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push     = w_evt && (!w_full || w_pop);
    assign w_drop     = w_evt && w_full && !w_pop;
    assign w_evt_word = pack_event(chk_i == STAGE_CODE, r_evt_count, stg_i, chk_i);

    // Next-state selection; pass/fail take precedence over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ARMED;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ARMED: begin
                if (w_is_pass) begin
                    w_next = S_DRAIN;
                end else if (w_is_fail || w_tmo_hit) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ARMED;
                end
            end
            S_DRAIN: begin
                if (w_drn_end) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next = S_ARMED;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_cnt + CW'(1);
            2'b01:   w_cnt_next = r_cnt - CW'(1);
            default: w_cnt_next = r_cnt;
        endcase
    end

    // State register, run counters and sticky result flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_evt_count <= '0;
            r_prev      <= '0;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_ARMED) || (w_next == S_DRAIN);
            r_done  <= (w_next == S_DONE);
            if (w_arm) begin
                r_pass      <= 1'b0;
                r_fail      <= 1'b0;
                r_timeout   <= 1'b0;
                r_overflow  <= 1'b0;
                r_evt_count <= '0;
                r_prev      <= '0;
                r_tcnt      <= '0;
                r_dcnt      <= '0;
            end else begin
                if (r_state == S_ARMED) begin
                    r_tcnt <= r_tcnt + TMO_W'(1);
                end
                if (w_evt) begin
                    r_prev      <= chk_i;
                    r_evt_count <= r_evt_count + SEQ_W'(1);
                end
                if (w_is_pass) begin
                    r_pass <= 1'b1;
                end
                if (w_is_fail) begin
                    r_fail <= 1'b1;
                end
                if (w_tmo_hit && !w_is_pass && !w_is_fail) begin
                    r_timeout <= 1'b1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_is_pass) begin
                    r_dcnt <= '0;
                end else if (r_state == S_DRAIN) begin
                    r_dcnt <= r_dcnt + DRN_W'(1);
                end
            end
        end
    end

    // FIFO pointers and occupancy; arming flushes any stale entries
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_arm) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt   <= w_cnt_next;
            r_valid <= (w_cnt_next != '0);
        end
    end

    // FIFO storage; contents are qualified by r_valid so no reset is needed
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_evt_word;
        end
    end

    assign evt_valid = r_valid;
    assign evt_data  = r_mem[r_rd_ptr];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;
    assign evt_count = r_evt_count;

endmodule
